sensor_io_bridge: RTL and testbench
===================================

SENSOR_IO_BRIDGE -- requirements
Module: sensor_io_bridge

Interface
REQ-001 SHALL have parameters: NUM_IN, default 8, number of digital input channels (1..32).
REQ-002 SHALL have parameter PWM_W, default 16, PWM counter/period/duty width (1..32).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (>=2).
REQ-004 SHALL have parameter BASE_ADDR, default 12'hF00, 8-word-aligned base address in the data-memory map.
REQ-005 SHALL have ports: clock  in  1  single clock, all logic on rising edge.
REQ-006 SHALL have port: reset  in  1  synchronous, active-high.
REQ-007 SHALL have port: wren  in  1  data-bus write strobe.
REQ-008 SHALL have port: address  in  12  data-bus word address.
REQ-009 SHALL have port: data  in  32  write data.
REQ-010 SHALL have port: q  out  32  registered read data.
REQ-011 SHALL have port: in_pins  in  NUM_IN  asynchronous external inputs.
REQ-012 SHALL have port: out_pwm  out  1  PWM output.
REQ-013 SHALL have port: temp_out  out  32  temperature value written by software.
REQ-014 SHALL have port: irq  out  1  level interrupt.

Function
REQ-015 SHALL select when address[11:3]==BASE_ADDR[11:3]; register index = address[2:0].
REQ-016 SHALL map: 0 IN_STATE (RO, synced inputs), 1 EDGE (rising-edge sticky, W1C), 2 IRQ_EN (RW, NUM_IN bits), 3 PWM_PERIOD (RW), 4 PWM_DUTY (RW), 5 TEMP (RW), 6 CTRL (RW, bit0 pwm_en), 7 reserved (reads 0, writes ignored).
REQ-017 SHALL register q one cycle after the address; q = 0 when not selected; unused upper bits read 0.
REQ-018 SHALL pass each in_pins bit through SYNC_STAGES flops before use; IN_STATE reflects the last stage.
REQ-019 SHALL set EDGE[i] on a 0->1 transition of synced bit i; writing 1 clears, writing 0 has no effect.
REQ-020 SHALL give set priority when a new edge and a W1C clear hit the same bit in the same cycle.
REQ-021 SHALL drive irq = |(EDGE & IRQ_EN), registered, asserting one cycle after EDGE sets.
REQ-022 SHALL run PWM counter 0..PERIOD then wrap to 0 while pwm_en=1; counter held at 0 while pwm_en=0.
REQ-023 SHALL drive out_pwm high when pwm_en=1 and counter < active duty; otherwise low.
REQ-024 SHALL hold written PERIOD/DUTY in shadow registers, loading active values only at counter wrap or while pwm_en=0.
REQ-025 SHALL force out_pwm low when active PERIOD=0; out_pwm constantly high when duty > PERIOD.
REQ-026 SHALL drive temp_out directly from TEMP register.

Reset
REQ-027 SHALL clear on reset: q, EDGE, IRQ_EN, PERIOD, DUTY (shadow and active), TEMP, CTRL, PWM counter, sync flops; out_pwm=0, irq=0, temp_out=0.
REQ-028 SHALL abort any PWM cycle and discard pending writes when reset asserts mid-operation; no edge is reported from the post-reset sync refill.

Configuration
REQ-029 SHALL, with SENSOR_IO_DEBOUNCE_EN defined, require each synced input to be stable for DEBOUNCE_CYCLES (parameter, default 16) consecutive cycles before IN_STATE/edge logic sees it.
REQ-030 SHALL, without SENSOR_IO_DEBOUNCE_EN, feed IN_STATE directly from the synchroniser; DEBOUNCE_CYCLES ignored.

Structure
REQ-031 SHALL place register indices, CTRL bit positions and reset values in package sensor_io_pkg.
REQ-032 SHALL implement per-channel synchroniser plus optional debounce as sub-module sensor_io_sync, instantiated NUM_IN times.

Verification
REQ-033 SHALL cover: in_pins[3] 0->1 held -> IN_STATE bit3=1 after SYNC_STAGES+1 cycles, EDGE=0x08.
REQ-034 SHALL cover: IRQ_EN=0x08, edge on ch3 -> irq=1; write EDGE=0x08 -> irq=0 next cycle; clear coincident with new edge -> bit stays 1.
REQ-035 SHALL cover: PERIOD=9, DUTY=3, pwm_en=1 -> out_pwm 3 high / 7 low repeating; DUTY=0 -> always low; DUTY=12 -> always high.
REQ-036 SHALL cover: DUTY changed 3->6 mid-period -> old duty finishes, new duty from next wrap.
REQ-037 SHALL cover: TEMP write 0x0000_0019 -> temp_out=0x19 next cycle; read at BASE+5 returns 0x19 one cycle later; address BASE+8 returns 0.
REQ-038 SHALL cover: reset asserted mid-PWM with EDGE=0xFF -> all outputs 0 next cycle; with SENSOR_IO_DEBOUNCE_EN, 10-cycle glitch ignored, 16-cycle pulse registered.

Source files
------------

// File: rtl/sensor_io_pkg.sv
// Shared definitions for the sensor I/O bridge: register indices, CTRL bit
// positions and reset values.
package sensor_io_pkg;

    typedef enum logic [2:0] {
        REG_IN_STATE   = 3'd0,
        REG_EDGE       = 3'd1,
        REG_IRQ_EN     = 3'd2,
        REG_PWM_PERIOD = 3'd3,
        REG_PWM_DUTY   = 3'd4,
        REG_TEMP       = 3'd5,
        REG_CTRL       = 3'd6,
        REG_RSVD       = 3'd7
    } reg_idx_e;

    localparam int          CTRL_PWM_EN_BIT = 0;

    localparam logic [31:0] RST_WORD   = 32'h0000_0000;
    localparam logic [31:0] RST_TEMP   = 32'h0000_0000;
    localparam logic        RST_PWM_EN = 1'b0;

endpackage

// File: rtl/sensor_io_sync.sv
// One input channel: SYNC_STAGES-deep synchroniser, plus a stability filter
// when SENSOR_IO_DEBOUNCE_EN is defined.
module sensor_io_sync #(
    parameter int SYNC_STAGES     = 2
`ifdef SENSOR_IO_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = 16
`endif
) (
    input  logic clock,
    input  logic reset,
    input  logic pin_i,
    output logic level_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
        end
    end

`ifdef SENSOR_IO_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             synced;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;

    assign synced = sync_q[SYNC_STAGES-1];

    // Down-counter restarts whenever the synced value falls back to the
    // accepted level, so only an unbroken run of differing samples is taken.
    always_ff @(posedge clock) begin
        if (reset) begin
            level_q <= 1'b0;
            cnt_q   <= CNT_LOAD;
        end else if (synced == level_q) begin
            cnt_q   <= CNT_LOAD;
        end else if (cnt_q == '0) begin
            level_q <= synced;
            cnt_q   <= CNT_LOAD;
        end else begin
            cnt_q   <= cnt_q - 1'b1;
        end
    end

    assign level_o = level_q;
`else
    assign level_o = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/sensor_io_bridge.sv
// Memory-mapped bridge: synced digital inputs with sticky edge/IRQ, a PWM
// output with shadowed period/duty, and a software TEMP register.
// Optional input debounce is enabled by defining SENSOR_IO_DEBOUNCE_EN.
module sensor_io_bridge
    import sensor_io_pkg::*;
#(
    parameter int          NUM_IN          = 8,
    parameter int          PWM_W           = 16,
    parameter int          SYNC_STAGES     = 2,
    parameter logic [11:0] BASE_ADDR       = 12'hF00,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wren,
    input  logic [11:0]       address,
    input  logic [31:0]       data,
    output logic [31:0]       q,
    input  logic [NUM_IN-1:0] in_pins,
    output logic              out_pwm,
    output logic [31:0]       temp_out,
    output logic              irq
);

`ifdef SENSOR_IO_DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
`else
    localparam bit DEB_ON = 1'b0;
`endif
    localparam int DEB_LAT      = DEB_ON ? DEBOUNCE_CYCLES : 0;
    // Edges stay masked until the synchroniser (and filter) has refilled.
    localparam int GUARD_CYCLES = SYNC_STAGES + 1 + DEB_LAT;
    localparam int GUARD_W      = $clog2(GUARD_CYCLES + 1);
    localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYCLES);

    logic [NUM_IN-1:0]  in_state;
    logic [NUM_IN-1:0]  in_prev_q;
    logic [NUM_IN-1:0]  rise;
    logic [NUM_IN-1:0]  edge_clr;
    logic [NUM_IN-1:0]  edge_q, edge_d;
    logic [NUM_IN-1:0]  irq_en_q, irq_en_d;
    logic [PWM_W-1:0]   per_sh_q, per_sh_d;
    logic [PWM_W-1:0]   duty_sh_q, duty_sh_d;
    logic [PWM_W-1:0]   per_act_q, per_act_d;
    logic [PWM_W-1:0]   duty_act_q, duty_act_d;
    logic [PWM_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        temp_q, temp_d;
    logic               pwm_en_q, pwm_en_d;
    logic [31:0]        q_q, q_d;
    logic               irq_q, irq_d;
    logic [GUARD_W-1:0] guard_q, guard_d;
    logic [31:0]        rd_data;
    logic               sel;
    logic               wr;
    reg_idx_e           idx;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
`ifdef SENSOR_IO_DEBOUNCE_EN
        sensor_io_sync #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_sync (
            .clock  (clock),
            .reset  (reset),
            .pin_i  (in_pins[i]),
            .level_o(in_state[i])
        );
`else
        sensor_io_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clock  (clock),
            .reset  (reset),
            .pin_i  (in_pins[i]),
            .level_o(in_state[i])
        );
`endif
    end

    assign sel = (address[11:3] == BASE_ADDR[11:3]);
    assign wr  = wren && sel;
    assign idx = reg_idx_e'(address[2:0]);

    always_comb begin
        rd_data = '0;
        case (idx)
            REG_IN_STATE:   rd_data[NUM_IN-1:0] = in_state;
            REG_EDGE:       rd_data[NUM_IN-1:0] = edge_q;
            REG_IRQ_EN:     rd_data[NUM_IN-1:0] = irq_en_q;
            REG_PWM_PERIOD: rd_data[PWM_W-1:0]  = per_sh_q;
            REG_PWM_DUTY:   rd_data[PWM_W-1:0]  = duty_sh_q;
            REG_TEMP:       rd_data             = temp_q;
            REG_CTRL:       rd_data[CTRL_PWM_EN_BIT] = pwm_en_q;
            default:        rd_data = '0;
        endcase
    end

    always_comb begin
        q_d       = sel ? rd_data : '0;
        irq_en_d  = irq_en_q;
        per_sh_d  = per_sh_q;
        duty_sh_d = duty_sh_q;
        temp_d    = temp_q;
        pwm_en_d  = pwm_en_q;
        edge_clr  = '0;
        if (wr) begin
            case (idx)
                REG_EDGE:       edge_clr  = data[NUM_IN-1:0];
                REG_IRQ_EN:     irq_en_d  = data[NUM_IN-1:0];
                REG_PWM_PERIOD: per_sh_d  = data[PWM_W-1:0];
                REG_PWM_DUTY:   duty_sh_d = data[PWM_W-1:0];
                REG_TEMP:       temp_d    = data;
                REG_CTRL:       pwm_en_d  = data[CTRL_PWM_EN_BIT];
                default:        ;
            endcase
        end
    end

    // A fresh rising edge wins over a same-cycle write-one-to-clear.
    always_comb begin
        guard_d = (guard_q == '0) ? '0 : guard_q - 1'b1;
        rise    = (guard_q == '0) ? (in_state & ~in_prev_q) : '0;
        edge_d  = (edge_q & ~edge_clr) | rise;
        irq_d   = |(edge_q & irq_en_q);
    end

    always_comb begin
        cnt_d      = cnt_q;
        per_act_d  = per_act_q;
        duty_act_d = duty_act_q;
        if (!pwm_en_q) begin
            cnt_d      = '0;
            per_act_d  = per_sh_q;
            duty_act_d = duty_sh_q;
        end else if (cnt_q == per_act_q) begin
            cnt_d      = '0;
            per_act_d  = per_sh_q;
            duty_act_d = duty_sh_q;
        end else begin
            cnt_d      = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_q        <= RST_WORD;
            edge_q     <= RST_WORD[NUM_IN-1:0];
            irq_en_q   <= RST_WORD[NUM_IN-1:0];
            in_prev_q  <= RST_WORD[NUM_IN-1:0];
            per_sh_q   <= RST_WORD[PWM_W-1:0];
            duty_sh_q  <= RST_WORD[PWM_W-1:0];
            per_act_q  <= RST_WORD[PWM_W-1:0];
            duty_act_q <= RST_WORD[PWM_W-1:0];
            cnt_q      <= RST_WORD[PWM_W-1:0];
            temp_q     <= RST_TEMP;
            pwm_en_q   <= RST_PWM_EN;
            irq_q      <= 1'b0;
            guard_q    <= GUARD_LOAD;
        end else begin
            q_q        <= q_d;
            edge_q     <= edge_d;
            irq_en_q   <= irq_en_d;
            in_prev_q  <= in_state;
            per_sh_q   <= per_sh_d;
            duty_sh_q  <= duty_sh_d;
            per_act_q  <= per_act_d;
            duty_act_q <= duty_act_d;
            cnt_q      <= cnt_d;
            temp_q     <= temp_d;
            pwm_en_q   <= pwm_en_d;
            irq_q      <= irq_d;
            guard_q    <= guard_d;
        end
    end

    assign q        = q_q;
    assign irq      = irq_q;
    assign temp_out = temp_q;
    assign out_pwm  = pwm_en_q && (per_act_q != '0) && (cnt_q < duty_act_q);

endmodule

// File: tb/tb_sensor_io_bridge.sv
// Self-checking bench for sensor_io_bridge with a behavioural register/PWM
// model; the debounce scenario runs when SENSOR_IO_DEBOUNCE_EN is defined.
module tb_sensor_io_bridge;

    localparam int          NUM_IN  = 8;
    localparam int          PWM_W   = 16;
    localparam int          SYNC    = 2;
    localparam int          DEB     = 16;
    localparam logic [11:0] BASE    = 12'hF00;
`ifdef SENSOR_IO_DEBOUNCE_EN
    localparam int          LAT     = SYNC + 1 + DEB;
`else
    localparam int          LAT     = SYNC + 1;
`endif
    localparam int          SETTLE  = LAT + 3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              wren = 1'b0;
    logic [11:0]       address = 12'h000;
    logic [31:0]       data = 32'h0;
    logic [31:0]       q;
    logic [NUM_IN-1:0] in_pins = '0;
    logic              out_pwm;
    logic [31:0]       temp_out;
    logic              irq;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_cyc = 0;

    logic [NUM_IN-1:0] m_pins = '0;
    logic [NUM_IN-1:0] m_edge = '0;
    logic [NUM_IN-1:0] m_irq_en = '0;

    sensor_io_bridge #(
        .NUM_IN         (NUM_IN),
        .PWM_W          (PWM_W),
        .SYNC_STAGES    (SYNC),
        .BASE_ADDR      (BASE),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .wren    (wren),
        .address (address),
        .data    (data),
        .q       (q),
        .in_pins (in_pins),
        .out_pwm (out_pwm),
        .temp_out(temp_out),
        .irq     (irq)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    task automatic do_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clock);
        wren = 1'b1;
        address = a;
        data = d;
        @(posedge clock);
        #1;
        wren = 1'b0;
        last_cyc = cyc;
    endtask

    task automatic do_read(input logic [11:0] a, output logic [31:0] v);
        @(negedge clock);
        wren = 1'b0;
        address = a;
        @(posedge clock);
        @(negedge clock);
        v = q;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if (q !== 32'h0 || out_pwm !== 1'b0 || irq !== 1'b0 || temp_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: q=%h pwm=%b irq=%b temp=%h, required all zero", q, out_pwm, irq, temp_out);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (SETTLE) @(negedge clock);
        begin
            logic [31:0] v;
            do_read(BASE + 12'd1, v);
            checks++;
            if (v !== 32'h0) begin
                errors++;
                $display("FAIL reset_edge: got %h required 0", v);
            end
        end
    endtask

    task automatic test_edge_latency();
        logic [31:0] v;
        logic [31:0] exp;
        @(negedge clock);
        in_pins[3] = 1'b1;
        address = BASE;
        wren = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            @(posedge clock);
            @(negedge clock);
            exp = (i >= LAT) ? 32'h8 : 32'h0;
            checks++;
            if (q !== exp) begin
                errors++;
                $display("FAIL in_state_latency cycle %0d: got %h required %h", i, q, exp);
            end
        end
        m_edge = m_edge | (8'h08 & ~m_pins);
        m_pins = 8'h08;
        do_read(BASE + 12'd1, v);
        checks++;
        if (v !== 32'h8) begin
            errors++;
            $display("FAIL edge_ch3: got %h required 00000008", v);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_masked: got %b required 0", irq);
        end
    endtask

    task automatic test_irq();
        logic [31:0] v;
        do_write(BASE + 12'd2, 32'h08);
        m_irq_en = 8'h08;
        repeat (2) @(negedge clock);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set: got %b required 1", irq);
        end
        do_write(BASE + 12'd1, 32'h08);
        m_edge = m_edge & ~8'h08;
        repeat (2) @(negedge clock);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear: got %b required 0", irq);
        end
        @(negedge clock);
        in_pins[3] = 1'b0;
        repeat (SETTLE) @(negedge clock);
        in_pins[3] = 1'b1;
        repeat (LAT - 1) @(posedge clock);
        @(negedge clock);
        wren = 1'b1;
        address = BASE + 12'd1;
        data = 32'h08;
        @(posedge clock);
        #1;
        wren = 1'b0;
        m_edge = m_edge | 8'h08;
        do_read(BASE + 12'd1, v);
        checks++;
        if (v !== {24'h0, m_edge}) begin
            errors++;
            $display("FAIL edge_set_priority: got %h required %h", v, m_edge);
        end
        @(negedge clock);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_after_priority: got %b required 1", irq);
        end
    endtask

    task automatic test_edge_random();
        logic [31:0] v;
        logic [NUM_IN-1:0] nv;
        logic [NUM_IN-1:0] msk;
        for (int r = 0; r < 12; r++) begin
            nv = NUM_IN'($urandom);
            @(negedge clock);
            in_pins = nv;
            repeat (SETTLE) @(negedge clock);
            m_edge = m_edge | (nv & ~m_pins);
            m_pins = nv;
            do_read(BASE, v);
            checks++;
            if (v !== {24'h0, m_pins}) begin
                errors++;
                $display("FAIL rand_in_state r%0d: got %h required %h", r, v, m_pins);
            end
            do_read(BASE + 12'd1, v);
            checks++;
            if (v !== {24'h0, m_edge}) begin
                errors++;
                $display("FAIL rand_edge r%0d: got %h required %h", r, v, m_edge);
            end
            checks++;
            if (irq !== |(m_edge & m_irq_en)) begin
                errors++;
                $display("FAIL rand_irq r%0d: got %b required %b", r, irq, |(m_edge & m_irq_en));
            end
            if ($urandom_range(0, 1) == 1) begin
                msk = NUM_IN'($urandom);
                do_write(BASE + 12'd1, {24'h0, msk});
                m_edge = m_edge & ~msk;
            end
            if ($urandom_range(0, 2) == 0) begin
                msk = NUM_IN'($urandom);
                do_write(BASE + 12'd2, {24'hFFFFFF, msk});
                m_irq_en = msk;
            end
        end
    endtask

    task automatic test_pwm(input int p, input int d, input int n);
        logic exp;
        int k;
        do_write(BASE + 12'd6, 32'h0);
        do_write(BASE + 12'd3, p);
        do_write(BASE + 12'd4, d);
        @(negedge clock);
        checks++;
        if (out_pwm !== 1'b0) begin
            errors++;
            $display("FAIL pwm_disabled P=%0d D=%0d: got %b required 0", p, d, out_pwm);
        end
        do_write(BASE + 12'd6, 32'h1);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            k = cyc - last_cyc;
            exp = (p != 0) && ((k % (p + 1)) < d);
            checks++;
            if (out_pwm !== exp) begin
                errors++;
                $display("FAIL pwm P=%0d D=%0d k=%0d: got %b required %b", p, d, k, out_pwm, exp);
            end
        end
    endtask

    task automatic test_duty_change();
        logic exp;
        int k;
        int en;
        int dd;
        do_write(BASE + 12'd6, 32'h0);
        do_write(BASE + 12'd3, 32'd9);
        do_write(BASE + 12'd4, 32'd3);
        do_write(BASE + 12'd6, 32'h1);
        en = last_cyc;
        for (int i = 0; i < 42; i++) begin
            @(negedge clock);
            k = cyc - en;
            // Write lands on the edge that starts k=16; new duty from the next period.
            dd = (((k / 10) * 10) > 16) ? 6 : 3;
            exp = (k % 10) < dd;
            checks++;
            if (out_pwm !== exp) begin
                errors++;
                $display("FAIL duty_change k=%0d: got %b required %b", k, out_pwm, exp);
            end
            if (k == 15) begin
                wren = 1'b1;
                address = BASE + 12'd4;
                data = 32'd6;
            end else begin
                wren = 1'b0;
            end
        end
    endtask

    task automatic test_temp();
        logic [31:0] v;
        do_write(BASE + 12'd5, 32'h0000_0019);
        @(negedge clock);
        checks++;
        if (temp_out !== 32'h19) begin
            errors++;
            $display("FAIL temp_out: got %h required 00000019", temp_out);
        end
        do_read(BASE + 12'd5, v);
        checks++;
        if (v !== 32'h19) begin
            errors++;
            $display("FAIL temp_read: got %h required 00000019", v);
        end
        do_read(BASE + 12'd8, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL unselected_read: got %h required 0", v);
        end
        do_write(BASE + 12'd13, 32'hDEAD_BEEF);
        @(negedge clock);
        checks++;
        if (temp_out !== 32'h19) begin
            errors++;
            $display("FAIL unselected_write: got %h required 00000019", temp_out);
        end
        do_write(BASE + 12'd7, 32'hFFFF_FFFF);
        do_read(BASE + 12'd7, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL reserved_read: got %h required 0", v);
        end
        do_write(BASE + 12'd3, 32'hABCD_1234);
        do_read(BASE + 12'd3, v);
        checks++;
        if (v !== 32'h0000_1234) begin
            errors++;
            $display("FAIL period_readback: got %h required 00001234", v);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        @(negedge clock);
        in_pins = '0;
        repeat (SETTLE) @(negedge clock);
        do_write(BASE + 12'd1, 32'hFF);
        @(negedge clock);
        in_pins = '1;
        repeat (SETTLE) @(negedge clock);
        do_write(BASE + 12'd2, 32'hFF);
        do_write(BASE + 12'd5, 32'h0000_0077);
        do_write(BASE + 12'd6, 32'h0);
        do_write(BASE + 12'd3, 32'd9);
        do_write(BASE + 12'd4, 32'd3);
        do_write(BASE + 12'd6, 32'h1);
        do_read(BASE + 12'd1, v);
        checks++;
        if (v !== 32'hFF || irq !== 1'b1 || out_pwm !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: edge=%h irq=%b pwm=%b required ff/1/1", v, irq, out_pwm);
        end
        @(negedge clock);
        reset = 1'b1;
        wren = 1'b1;
        address = BASE + 12'd5;
        data = 32'hABCD_0000;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (q !== 32'h0 || out_pwm !== 1'b0 || irq !== 1'b0 || temp_out !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: q=%h pwm=%b irq=%b temp=%h, required all zero", q, out_pwm, irq, temp_out);
        end
        reset = 1'b0;
        wren = 1'b0;
        m_edge = '0;
        m_irq_en = '0;
        m_pins = '1;
        repeat (SETTLE + 2) @(negedge clock);
        do_read(BASE + 12'd1, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL refill_edge: got %h required 0", v);
        end
        do_read(BASE, v);
        checks++;
        if (v !== 32'hFF) begin
            errors++;
            $display("FAIL refill_in_state: got %h required 000000ff", v);
        end
        checks++;
        if (temp_out !== 32'h0 || out_pwm !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_outputs: temp=%h pwm=%b irq=%b required zero", temp_out, out_pwm, irq);
        end
    endtask

`ifdef SENSOR_IO_DEBOUNCE_EN
    task automatic test_debounce();
        logic [31:0] v;
        @(negedge clock);
        in_pins = '0;
        repeat (SETTLE) @(negedge clock);
        do_write(BASE + 12'd1, 32'hFF);
        @(negedge clock);
        in_pins[0] = 1'b1;
        repeat (10) @(posedge clock);
        @(negedge clock);
        in_pins[0] = 1'b0;
        repeat (SETTLE) @(negedge clock);
        do_read(BASE + 12'd1, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL debounce_glitch: got %h required 0", v);
        end
        @(negedge clock);
        in_pins[0] = 1'b1;
        repeat (16) @(posedge clock);
        @(negedge clock);
        in_pins[0] = 1'b0;
        repeat (SETTLE) @(negedge clock);
        do_read(BASE + 12'd1, v);
        checks++;
        if (v !== 32'h1) begin
            errors++;
            $display("FAIL debounce_pulse: got %h required 00000001", v);
        end
    endtask
`endif

    initial begin
        int p;
        int d;
        test_reset();
        test_edge_latency();
        test_irq();
        test_edge_random();
        test_pwm(9, 3, 30);
        test_pwm(9, 0, 20);
        test_pwm(9, 12, 20);
        test_pwm(0, 5, 8);
        test_pwm(1, 1, 8);
        for (int r = 0; r < 5; r++) begin
            p = $urandom_range(1, 12);
            d = $urandom_range(0, p + 3);
            test_pwm(p, d, 3 * (p + 1));
        end
        test_duty_change();
        test_temp();
        test_reset_mid();
`ifdef SENSOR_IO_DEBOUNCE_EN
        test_debounce();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
